// File: rtl/mul_arbiter.sv
// Four-requester round-robin arbiter in front of a single fixed-latency multiplier.
// Define MUL_ARB_STATS_EN to add the saturating op_count_o completion counter.
module mul_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int MUL_LAT   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [3:0]             req_i,
    input  logic [4*DATAWIDTH-1:0] opa_flat_i,
    input  logic [4*DATAWIDTH-1:0] opb_flat_i,
    output logic [3:0]             gnt_o,
    output logic [3:0]             rsp_valid_o,
    output logic [DATAWIDTH-1:0]   result_o,
    output logic                   busy_o
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]            op_count_o
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [DATAWIDTH-1:0] opa_q, opa_d;
    logic [DATAWIDTH-1:0] opb_q, opb_d;
    logic [3:0]           gnt_q, gnt_d;
    logic [3:0]           rsp_q, rsp_d;
    logic [DATAWIDTH-1:0] result_q, result_d;

    logic [1:0]           winner;
    logic [DATAWIDTH-1:0] opaSel;
    logic [DATAWIDTH-1:0] opbSel;

    // Scan downward so the requester closest to ptr_q (lowest offset) wins last.
    always_comb begin
        winner = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req_i[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        opaSel = '0;
        opbSel = '0;
        for (int i = 0; i < 4; i++) begin
            if (winner == 2'(i)) begin
                opaSel = opa_flat_i[i*DATAWIDTH +: DATAWIDTH];
                opbSel = opb_flat_i[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        gnt_d    = '0;
        rsp_d    = '0;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (req_i != 4'b0000) begin
                    idx_d   = winner;
                    opa_d   = opaSel;
                    opb_d   = opbSel;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = 4'(MUL_LAT);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Truncating product: the upper DATAWIDTH bits are intentionally dropped.
                    result_d = opa_q * opb_q;
                    rsp_d    = 4'b0001 << idx_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                ptr_d   = idx_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            gnt_q    <= '0;
            rsp_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            gnt_q    <= gnt_d;
            rsp_q    <= rsp_d;
            result_q <= result_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_q;
    assign result_o    = result_q;
    assign busy_o      = (state_q != IDLE);

`ifdef MUL_ARB_STATS_EN
    logic [15:0] opCount_q;

    // Counts completions as they are issued, sticking at the maximum value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opCount_q <= '0;
        end else if ((rsp_d != 4'b0000) && (opCount_q != 16'hFFFF)) begin
            opCount_q <= opCount_q + 16'd1;
        end
    end

    assign op_count_o = opCount_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: a transaction-level round-robin model predicts
// the completion order and products; an independent monitor checks every pulse.
module tb_mul_arbiter;

    localparam int DW      = 32;
    localparam int MUL_LAT = 2;

    logic          clk_i;
    logic          rst_ni;
    logic [3:0]    req_i;
    logic [4*DW-1:0] opa_flat_i;
    logic [4*DW-1:0] opb_flat_i;
    logic [3:0]    gnt_o;
    logic [3:0]    rsp_valid_o;
    logic [DW-1:0] result_o;
    logic          busy_o;
`ifdef MUL_ARB_STATS_EN
    logic [15:0]   op_count_o;
`endif

    mul_arbiter #(.DATAWIDTH(DW), .MUL_LAT(MUL_LAT)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .opa_flat_i  (opa_flat_i),
        .opb_flat_i  (opb_flat_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .result_o    (result_o),
        .busy_o      (busy_o)
`ifdef MUL_ARB_STATS_EN
        ,
        .op_count_o  (op_count_o)
`endif
    );

    typedef struct {
        int          idx;
        logic [DW-1:0] res;
    } exp_t;

    exp_t          expQ[$];
    int            rspCycleQ[$];
    logic [DW-1:0] opA[4];
    logic [DW-1:0] opB[4];
    logic [DW-1:0] lastResult;
    int            modelPtr;
    int            checks;
    int            errors;
    int            cycleCount;
    int            gntCycle;
    int            opsSinceReset;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples one time unit after each rising edge and consumes the scoreboard.
    always begin
        exp_t e;
        @(posedge clk_i);
        #1;
        cycleCount++;
        if (rst_ni) begin
            if (gnt_o != 4'b0000) begin
                gntCycle = cycleCount;
                checkOutput("gnt_busy", 64'(busy_o), 64'd1);
                if (expQ.size() == 0) begin
                    checkOutput("gnt_unexpected", 64'(gnt_o), 64'd0);
                end else begin
                    checkOutput("gnt_onehot", 64'(gnt_o), 64'(4'b0001 << expQ[0].idx));
                end
            end
            if (rsp_valid_o != 4'b0000) begin
                if (expQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_onehot", 64'(rsp_valid_o), 64'(4'b0001 << e.idx));
                    checkOutput("rsp_result", 64'(result_o), 64'(e.res));
                    checkOutput("rsp_latency", 64'(cycleCount - gntCycle), 64'(MUL_LAT));
                    checkOutput("rsp_busy", 64'(busy_o), 64'd1);
                    lastResult = e.res;
                    rspCycleQ.push_back(cycleCount);
                    opsSinceReset++;
                end
            end else begin
                checkOutput("result_hold", 64'(result_o), 64'(lastResult));
            end
        end
    end

    function automatic logic [DW-1:0] pickOperand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    // Raise the masked requests at once and serve them; called and returns on a falling edge.
    task automatic applyStimulus(input logic [3:0] mask, input bit scramble);
        int          order[$];
        logic [3:0]  pending;
        int          waited;
        exp_t        e;
        for (int k = 0; k < 4; k++) begin
            if (mask[(modelPtr + k) % 4]) order.push_back((modelPtr + k) % 4);
        end
        foreach (order[j]) begin
            e.idx = order[j];
            e.res = opA[order[j]] * opB[order[j]];
            expQ.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            opa_flat_i[i*DW +: DW] = opA[i];
            opb_flat_i[i*DW +: DW] = opB[i];
        end
        req_i   = mask;
        pending = mask;
        waited  = 0;
        while (pending != 4'b0000 && waited < 200) begin
            @(negedge clk_i);
            waited++;
            for (int i = 0; i < 4; i++) begin
                if (scramble && gnt_o[i]) begin
                    opa_flat_i[i*DW +: DW] = DW'($urandom);
                    opb_flat_i[i*DW +: DW] = DW'($urandom);
                end
                if (rsp_valid_o[i] && pending[i]) begin
                    pending[i] = 1'b0;
                    req_i[i]   = 1'b0;
                end
            end
        end
        checkOutput("batch_complete", 64'(pending), 64'd0);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        if (pending != 4'b0000) begin
            req_i = '0;
            expQ.delete();
        end
        modelPtr = (order[order.size()-1] + 1) % 4;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cycleCount    = 0;
        gntCycle      = 0;
        modelPtr      = 0;
        lastResult    = '0;
        opsSinceReset = 0;
        rst_ni        = 1'b0;
        req_i         = '0;
        opa_flat_i    = '0;
        opb_flat_i    = '0;
        #1;
        checkOutput("reset_gnt", 64'(gnt_o), 64'd0);
        checkOutput("reset_rsp", 64'(rsp_valid_o), 64'd0);
        checkOutput("reset_result", 64'(result_o), 64'd0);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // All four requesting from ptr 0: served 0,1,2,3 back to back.
        for (int i = 0; i < 4; i++) begin
            opA[i] = DW'(i + 2);
            opB[i] = DW'(10 * i + 3);
        end
        rspCycleQ.delete();
        applyStimulus(4'b1111, 1'b0);
        checkOutput("rr_count", 64'(rspCycleQ.size()), 64'd4);
        for (int j = 1; j < rspCycleQ.size(); j++) begin
            checkOutput("rr_spacing", 64'(rspCycleQ[j] - rspCycleQ[j-1]), 64'(MUL_LAT + 2));
        end

        opA[0] = 32'd3;
        opB[0] = 32'd7;
        applyStimulus(4'b0001, 1'b0);
        checkOutput("basic_3x7", 64'(result_o), 64'd21);

        opA[3] = 32'hFFFF_FFFF;
        opB[3] = 32'd2;
        applyStimulus(4'b1000, 1'b0);
        checkOutput("overflow", 64'(result_o), 64'hFFFF_FFFE);

        opA[1] = 32'd4;
        opB[1] = 32'd10;
        applyStimulus(4'b0010, 1'b1);
        checkOutput("inflight_change", 64'(result_o), 64'd40);

        // Reset one cycle after capturing requester 2 must abort with no response.
        begin
            exp_t e;
            @(negedge clk_i);
            opA[2] = DW'($urandom);
            opB[2] = DW'($urandom);
            opa_flat_i[2*DW +: DW] = opA[2];
            opb_flat_i[2*DW +: DW] = opB[2];
            e.idx = 2;
            e.res = opA[2] * opB[2];
            expQ.push_back(e);
            req_i = 4'b0100;
            @(negedge clk_i);
            rst_ni        = 1'b0;
            req_i         = '0;
            expQ.delete();
            lastResult    = '0;
            modelPtr      = 0;
            opsSinceReset = 0;
            #1;
            checkOutput("abort_busy", 64'(busy_o), 64'd0);
            checkOutput("abort_rsp", 64'(rsp_valid_o), 64'd0);
            checkOutput("abort_gnt", 64'(gnt_o), 64'd0);
            checkOutput("abort_result", 64'(result_o), 64'd0);
            repeat (2) @(negedge clk_i);
            rst_ni = 1'b1;
            repeat (3) @(negedge clk_i);
            opA[2] = 32'd5;
            opB[2] = 32'd5;
            applyStimulus(4'b0100, 1'b0);
            checkOutput("after_reset_5x5", 64'(result_o), 64'd25);
        end

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                opA[i] = pickOperand();
                opB[i] = pickOperand();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            applyStimulus(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk_i);
        checkOutput("final_idle", 64'(busy_o), 64'd0);
`ifdef MUL_ARB_STATS_EN
        checkOutput("op_count", 64'(op_count_o),
                    64'((opsSinceReset > 65535) ? 65535 : opsSinceReset));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32, operand and result width in bits.
REQ-002 Parameter MUL_LAT, default 2, multiplier latency in cycles; legal range 1..15.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 req  input  4  per-requester request; held high until the matching rsp_valid.
REQ-006 opa_flat  input  4*DATAWIDTH  operand A; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-007 opb_flat  input  4*DATAWIDTH  operand B; same packing as opa_flat.
REQ-008 gnt  output  4  one-hot grant pulse, one cycle, marks operand capture.
REQ-009 rsp_valid  output  4  one-hot completion pulse, one cycle.
REQ-010 result  output  DATAWIDTH  low DATAWIDTH bits of A*B; valid while rsp_valid is nonzero.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states IDLE, BUSY, DONE; exactly one multiply in flight.
REQ-013 IDLE with req==0: remain IDLE; gnt, rsp_valid = 0.
REQ-014 IDLE with req!=0: winner = first set bit scanning from ptr upward, mod 4.
REQ-015 Same edge: latch winner's operands and index; gnt=onehot(winner) for next cycle only; cnt=MUL_LAT; go BUSY.
REQ-016 BUSY: cnt decrements each edge; the edge at which cnt==1 registers result=(A*B) truncated to DATAWIDTH, sets rsp_valid=onehot(index), goes DONE.
REQ-017 Latency: rsp_valid high exactly MUL_LAT edges after the capture edge.
REQ-018 DONE: req ignored; next edge clears rsp_valid, sets ptr=(index+1) mod 4, goes IDLE.
REQ-019 result holds its last value after rsp_valid falls.
REQ-020 Requester drops req no later than the edge ending its rsp_valid cycle; req still high at the next IDLE edge is a new request.
REQ-021 Changes to req or operands while BUSY or DONE do not affect the in-flight operation.
REQ-022 Simultaneous requests: round-robin per REQ-014; each requester served within 4 operations.
REQ-023 Throughput: one operation per MUL_LAT+2 cycles under continuous load.
REQ-024 Signed/overflow: unsigned multiply; upper DATAWIDTH bits of the product are discarded.

Reset
REQ-025 Rst low: state=IDLE, ptr=0, cnt=0, index=0, gnt=0, rsp_valid=0, result=0, busy=0, immediately and asynchronously.
REQ-026 Reset mid-operation aborts it; no rsp_valid is ever issued for the aborted operation.
REQ-027 First arbitration occurs on the first rising edge with Rst high.

Configuration
REQ-028 Macro MUL_ARB_STATS_EN, when defined, adds output op_count (16 bits) counting rsp_valid pulses, saturating at 16'hFFFF, reset to 0.
REQ-029 Without MUL_ARB_STATS_EN, port op_count and its counter do not exist; all other behaviour is identical.

Verification
REQ-030 MUL_LAT=2, req=4'b0001, A0=3, B0=7 -> gnt=0001 one cycle after capture; rsp_valid=0001, result=21 exactly 2 edges after capture.
REQ-031 req=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0; rsp_valid spacing 4 cycles.
REQ-032 DATAWIDTH=32, A=32'hFFFFFFFF, B=2 -> result=32'hFFFFFFFE.
REQ-033 Rst low one cycle after capture for requester 2 -> busy=0, no rsp_valid; after release, req=0100 with A=5, B=5 -> result=25.
REQ-034 Requester 1 changes opa from 4 to 9 while BUSY (B=10) -> result=40.
REQ-035 With MUL_ARB_STATS_EN: 3 completed operations -> op_count=3; preload to 16'hFFFE, 3 more completions -> op_count=16'hFFFF.
